// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit, one bit per cycle.
// Optional macro MULDIV_ZERO_SKIP_EN: zero-operand cases finish in one cycle.
module muldiv_unit #(
   parameter int BITS  = 64,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               funct3,
   input  logic [BITS-1:0]          rs1_data,
   input  logic [BITS-1:0]          rs2_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   input  logic                     flush,
   output logic                     busy,
   output logic                     wb_en,
   output logic [$clog2(DEPTH)-1:0] wb_addr,
   output logic [BITS-1:0]          wb_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(BITS + 1);
   localparam logic [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};
   localparam logic [BITS-1:0] ONES = {BITS{1'b1}};
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t              state;
   logic [2:0]          op;
   logic [AW-1:0]       rd;
   logic [BITS-1:0]     a_mag;
   logic [BITS-1:0]     b_mag;
   logic                res_neg;
   logic [CW-1:0]       cnt;
   logic [2*BITS-1:0]   prod;
   logic [BITS:0]       rem;
   logic [BITS-1:0]     quo;

   logic                a_sgn;
   logic                b_sgn;
   logic                sa;
   logic                sb;
   logic                is_div;
   logic [BITS-1:0]     a_abs;
   logic [BITS-1:0]     b_abs;
   logic                sign_in;
   logic                special;
   logic [BITS-1:0]     special_res;

   logic [BITS:0]       mul_sum;
   logic [2*BITS-1:0]   prod_nx;
   logic [BITS:0]       div_sh;
   logic [BITS:0]       div_df;
   logic [BITS:0]       rem_nx;
   logic [BITS-1:0]     quo_nx;
   logic [2*BITS-1:0]   prod_s;
   logic [BITS-1:0]     quo_s;
   logic [BITS-1:0]     rem_s;
   logic [BITS-1:0]     fin;

   // Decode the incoming request: signedness, magnitudes, early-out cases.
   always_comb begin
      a_sgn = (funct3 == 3'b000) || (funct3 == 3'b001) ||
              (funct3 == 3'b010) || (funct3 == 3'b100) ||
              (funct3 == 3'b110);
      b_sgn = (funct3 == 3'b000) || (funct3 == 3'b001) ||
              (funct3 == 3'b100) || (funct3 == 3'b110);
      is_div = funct3[2];
      sa = a_sgn & rs1_data[BITS-1];
      sb = b_sgn & rs2_data[BITS-1];
      a_abs = sa ? -rs1_data : rs1_data;
      b_abs = sb ? -rs2_data : rs2_data;
      // Remainder follows the dividend; everything else is sa ^ sb.
      sign_in = (is_div && funct3[1]) ? sa : (sa ^ sb);
      special = 1'b0;
      special_res = '0;
      if (is_div && (rs2_data == '0)) begin
         special = 1'b1;
         special_res = funct3[1] ? rs1_data : ONES;
      end else if (is_div && !funct3[0] &&
                   (rs1_data == SMIN) && (rs2_data == ONES)) begin
         special = 1'b1;
         special_res = funct3[1] ? '0 : rs1_data;
      end
`ifdef MULDIV_ZERO_SKIP_EN
      if (!is_div && ((rs1_data == '0) || (rs2_data == '0))) begin
         special = 1'b1;
         special_res = '0;
      end else if (is_div && (rs1_data == '0) &&
                   (rs2_data != '0)) begin
         special = 1'b1;
         special_res = '0;
      end
`endif
   end

   // One shift-add / restoring-divide step and the sign-corrected result.
   always_comb begin
      mul_sum = {1'b0, prod[2*BITS-1:BITS]} +
                ({1'b0, a_mag} & {(BITS+1){prod[0]}});
      prod_nx = {mul_sum, prod[BITS-1:1]};
      div_sh = {rem[BITS-1:0], quo[BITS-1]};
      div_df = div_sh - {1'b0, b_mag};
      rem_nx = div_df[BITS] ? div_sh : div_df;
      quo_nx = {quo[BITS-2:0], ~div_df[BITS]};
      prod_s = res_neg ? -prod_nx : prod_nx;
      quo_s = res_neg ? -quo_nx : quo_nx;
      rem_s = res_neg ? -rem_nx[BITS-1:0] : rem_nx[BITS-1:0];
      fin = '0;
      unique case (1'b1)
         (op == 3'b000): fin = prod_s[BITS-1:0];
         (!op[2] && (op != 3'b000)): fin = prod_s[2*BITS-1:BITS];
         (op[2] && !op[1]): fin = quo_s;
         (op[2] && op[1]): fin = rem_s;
         default: fin = '0;
      endcase
   end

   // Control FSM, datapath registers and registered write-back outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op      <= '0;
         rd      <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         res_neg <= 1'b0;
         cnt     <= '0;
         prod    <= '0;
         rem     <= '0;
         quo     <= '0;
         busy    <= 1'b0;
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               wb_en <= 1'b0;
               if (start) begin
                  op      <= funct3;
                  rd      <= rd_addr;
                  a_mag   <= a_abs;
                  b_mag   <= b_abs;
                  res_neg <= sign_in;
                  cnt     <= '0;
                  prod    <= {{BITS{1'b0}}, b_abs};
                  rem     <= '0;
                  quo     <= a_abs;
                  busy    <= 1'b1;
                  if (special) begin
                     state   <= DONE;
                     wb_en   <= (rd_addr != '0);
                     wb_addr <= rd_addr;
                     wb_data <= special_res;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  wb_en <= 1'b0;
               end else begin
                  prod <= prod_nx;
                  rem  <= rem_nx;
                  quo  <= quo_nx;
                  cnt  <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     state   <= DONE;
                     wb_en   <= (rd != '0);
                     wb_addr <= rd;
                     wb_data <= fin;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               wb_en <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               wb_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against a plain-arithmetic RV64M model.
// Follows MULDIV_ZERO_SKIP_EN for the expected latency of zero operands.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic [4:0]  rd_addr;
   logic        flush;
   logic        busy;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit chk_on = 0;

   int s_cyc = 0;
   int end_cyc = -1;
   int wen_cyc = -1;
   logic [4:0]  e_addr = '0;
   logic [63:0] e_data = '0;
   string cur_nm = "none";

   localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   muldiv_unit #(.BITS(64), .DEPTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .funct3(funct3),
      .rs1_data(rs1_data),
      .rs2_data(rs2_data),
      .rd_addr(rd_addr),
      .flush(flush),
      .busy(busy),
      .wb_en(wb_en),
      .wb_addr(wb_addr),
      .wb_data(wb_data)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Cycle number: cycle N runs from posedge N-1 to posedge N.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] f,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
      logic [127:0] ea, eb, p;
      longint sa, sb;
      sa = longint'(a);
      sb = longint'(b);
      ea = (f == 3'd0 || f == 3'd1 || f == 3'd2) ?
           {{64{a[63]}}, a} : {64'd0, a};
      eb = (f == 3'd0 || f == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
      p = ea * eb;
      case (f)
         3'd0: return p[63:0];
         3'd1, 3'd2, 3'd3: return p[127:64];
         3'd4: begin
            if (b == 0) return ONES;
            if (a == SMIN && b == ONES) return a;
            return 64'(sa / sb);
         end
         3'd5: begin
            if (b == 0) return ONES;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == SMIN && b == ONES) return 64'd0;
            return 64'(sa % sb);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f,
                                 input logic [63:0] a,
                                 input logic [63:0] b);
      if (f[2] && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == SMIN && b == ONES) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
      if (!f[2] && (a == 0 || b == 0)) return 1;
      if (f[2] && a == 0 && b != 0) return 1;
`endif
      return 65;
   endfunction

   // Every cycle after reset: busy and wb_en timing, write-back payload.
   always @(negedge clk) begin
      if (chk_on) begin
         chk({cur_nm, " busy"}, 64'(busy),
             64'((cyc > s_cyc) && (cyc <= end_cyc)));
         chk({cur_nm, " wb_en"}, 64'(wb_en), 64'(cyc == wen_cyc));
         if (cyc == wen_cyc) begin
            chk({cur_nm, " wb_addr"}, 64'(wb_addr), 64'(e_addr));
            chk({cur_nm, " wb_data"}, wb_data, e_data);
         end
      end
   end

   // Called at negedge+1 with the unit idle; returns one cycle after DONE.
   task automatic run_op(input string nm, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] lit,
                         input bit poke = 0, input bit fl = 0);
      logic [63:0] exp;
      int lat;
      exp = model(f, a, b);
      chk({nm, " model"}, exp, lit);
      lat = lat_of(f, a, b);
      start = 1; funct3 = f; rs1_data = a; rs2_data = b;
      rd_addr = rd; flush = fl;
      cur_nm = nm;
      s_cyc = cyc;
      end_cyc = cyc + lat;
      wen_cyc = (rd != 0) ? cyc + lat : -1;
      e_addr = rd;
      e_data = exp;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk); #1;
         flush = 0;
         start = poke && (k == 10);
         if (poke && k == 10) begin
            funct3 = 3'd5; rs1_data = 64'd99; rs2_data = 64'd3;
            rd_addr = 5'd3;
         end
      end
   endtask

   // Starts a MUL to x9 and kills it at cycle 30 with flush or reset.
   task automatic run_abort(input string nm, input bit use_rst);
      start = 1; funct3 = 3'd0; rs1_data = 64'd5; rs2_data = 64'd6;
      rd_addr = 5'd9; flush = 0;
      cur_nm = nm;
      s_cyc = cyc;
      end_cyc = cyc + 65;
      wen_cyc = cyc + 65;
      e_addr = 5'd9;
      e_data = 64'd30;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk); #1;
         start = 0;
      end
      if (use_rst) begin
         rst = 1;
         #1;
         chk({nm, " rst busy"}, 64'(busy), 64'd0);
         chk({nm, " rst wb_en"}, 64'(wb_en), 64'd0);
         chk({nm, " rst wb_addr"}, 64'(wb_addr), 64'd0);
         chk({nm, " rst wb_data"}, wb_data, 64'd0);
      end else begin
         flush = 1;
      end
      end_cyc = cyc;
      wen_cyc = -1;
      @(negedge clk); #1;
      rst = 0;
      flush = 0;
   endtask

   initial begin
      rst = 1; start = 0; funct3 = 0; rs1_data = 0; rs2_data = 0;
      rd_addr = 0; flush = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset wb_en", 64'(wb_en), 64'd0);
      chk("reset wb_addr", 64'(wb_addr), 64'd0);
      chk("reset wb_data", wb_data, 64'd0);
      #1;
      rst = 0;
      chk_on = 1;
      @(negedge clk); #1;

      run_op("mul 7*-3", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
             64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mulhu ones", 3'd3, ONES, ONES, 5'd6,
             64'hFFFF_FFFF_FFFF_FFFE);
      run_op("mulh ones", 3'd1, ONES, ONES, 5'd7, 64'd0);
      run_op("mulhsu -1*ones", 3'd2, ONES, ONES, 5'd8, ONES, 1);
      run_op("mulh min*min", 3'd1, SMIN, SMIN, 5'd10,
             64'h4000_0000_0000_0000);
      run_op("mul shift", 3'd0, 64'h1234_5678_9ABC_DEF0, 64'h10, 5'd11,
             64'h2345_6789_ABCD_EF00);
      run_op("mulhu shift", 3'd3, 64'h1234_5678_9ABC_DEF0, 64'h10,
             5'd12, 64'h1);
      run_op("div -7/2", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13,
             64'hFFFF_FFFF_FFFF_FFFD);
      run_op("rem -7/2", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14,
             ONES);
      run_op("div 7/-2", 3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd15,
             64'hFFFF_FFFF_FFFF_FFFD, 0, 1);
      run_op("rem 7/-2", 3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd16,
             64'd1);
      run_op("divu 100/7", 3'd5, 64'd100, 64'd7, 5'd17, 64'd14);
      run_op("remu 100/7", 3'd7, 64'd100, 64'd7, 5'd18, 64'd2);
      run_op("divu ones/1", 3'd5, ONES, 64'd1, 5'd19, ONES);
      run_op("remu ones/1", 3'd7, ONES, 64'd1, 5'd20, 64'd0);
      run_op("divu 42/0", 3'd5, 64'd42, 64'd0, 5'd21, ONES);
      run_op("remu 42/0", 3'd7, 64'd42, 64'd0, 5'd22, 64'd42);
      run_op("div 42/0", 3'd4, 64'd42, 64'd0, 5'd23, ONES);
      run_op("rem min/-1", 3'd6, SMIN, ONES, 5'd24, 64'd0);
      run_op("div min/-1", 3'd4, SMIN, ONES, 5'd25, SMIN);
      run_op("mul 0*5", 3'd0, 64'd0, 64'd5, 5'd26, 64'd0);
      run_op("div 0/5", 3'd4, 64'd0, 64'd5, 5'd27, 64'd0);
      run_op("mul x0 3*4", 3'd0, 64'd3, 64'd4, 5'd0, 64'd12);

      run_abort("flush", 0);
      run_op("after flush", 3'd0, 64'd3, 64'd5, 5'd9, 64'd15);
      run_abort("reset", 1);
      run_op("after reset", 3'd5, 64'd1000, 64'd10, 5'd9, 64'd100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
